// File: rtl/cyclic_stream_mux_pkg.sv
// Shared types and helpers for the cyclic stream multiplexer.
//   buf_state_e : occupancy states of the 2-entry output buffer
//   log2up()    : pointer width for a given input count, never less than 1
package cyclic_stream_mux_pkg;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cyclic_stream_mux_skid.sv
// Two-entry elastic buffer between the slotted input side and the consumer.
// Its ready is a registered "not full" flag, so the downstream ready never
// reaches the upstream ready path combinationally.
//   clk, reset : clock, asynchronous active-high reset
//   in_valid   : push request (only honoured while not full)
//   in_data    : beat to push
//   in_ready   : buffer can accept a beat this cycle (registered)
//   out_valid  : buffer non-empty (registered)
//   out_data   : head entry
//   out_ready  : consumer pops the head this cycle
//
// state     | meaning
// BUF_EMPTY | no entry held, out_valid low
// BUF_ONE   | head valid, room for one more
// BUF_TWO   | head and tail valid, in_ready low
module cyclic_stream_mux_skid
  import cyclic_stream_mux_pkg::*;
#(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             valid_q, valid_d;
  logic             full_q, full_d;
  logic             push, pop;

  always_comb begin
    push    = in_valid && !full_q;
    pop     = valid_q && out_ready;
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      BUF_EMPTY: begin
        if (push) begin
          head_d  = in_data;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        // push+pop: the old head leaves, the new beat becomes the head
        if (push && pop) begin
          head_d = in_data;
        end else if (push) begin
          tail_d  = in_data;
          state_d = BUF_TWO;
        end else if (pop) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
    valid_d = (state_d != BUF_EMPTY);
    full_d  = (state_d == BUF_TWO);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      full_q  <= full_d;
    end
  end

  assign in_ready  = !full_q;
  assign out_valid = valid_q;
  assign out_data  = head_q;

endmodule

// File: rtl/cyclic_stream_mux.sv
// Time-slotted N:1 stream multiplexer. A free-running slot pointer visits
// inputs 0..NUM_REQS-1, one per cycle, regardless of traffic; the input
// owning the current slot may push one beat into a 2-entry output buffer.
//   clk, reset : clock, asynchronous active-high reset
//   valid_in   : per-input valid
//   data_in    : per-input payload, input i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ready_in   : per-input ready, one-hot on the current slot or zero
//   valid_out  : output beat available
//   data_out   : output payload
//   sel_out    : index of the input that produced data_out
//   ready_out  : downstream ready
module cyclic_stream_mux
  import cyclic_stream_mux_pkg::*;
#(
  parameter int NUM_REQS     = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int LOG_NUM_REQS = log2up(NUM_REQS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQS-1:0]            valid_in,
  input  logic [NUM_REQS*DATA_WIDTH-1:0] data_in,
  output logic [NUM_REQS-1:0]            ready_in,
  output logic                           valid_out,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic [LOG_NUM_REQS-1:0]        sel_out,
  input  logic                           ready_out
);

  localparam logic [LOG_NUM_REQS-1:0] LAST_SLOT = LOG_NUM_REQS'(NUM_REQS - 1);

  logic [LOG_NUM_REQS-1:0] ptr_q, ptr_d;
  logic [NUM_REQS-1:0]     slot_onehot;
  logic [DATA_WIDTH-1:0]   slot_data;
  logic                    buf_ready;
  logic                    push;

  // Explicit wrap keeps non-power-of-two counts from reaching unused slots.
  always_comb begin
    ptr_d = (ptr_q == LAST_SLOT) ? '0 : ptr_q + LOG_NUM_REQS'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    slot_onehot = '0;
    slot_data   = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (ptr_q == LOG_NUM_REQS'(i)) begin
        slot_onehot[i] = 1'b1;
        slot_data      = data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Reset gates ready directly: the buffer's full flag clears during reset,
  // but no input may see a grant until reset is released.
  assign ready_in = slot_onehot & {NUM_REQS{buf_ready & ~reset}};
  assign push     = |(valid_in & ready_in);

  cyclic_stream_mux_skid #(
    .WIDTH(DATA_WIDTH + LOG_NUM_REQS)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_valid (push),
    .in_data  ({slot_data, ptr_q}),
    .in_ready (buf_ready),
    .out_valid(valid_out),
    .out_data ({data_out, sel_out}),
    .out_ready(ready_out)
  );

`ifndef SYNTHESIS
  for (genvar g = 0; g < NUM_REQS; g++) begin : g_hold_chk
    a_valid_held : assert property (
      @(posedge clk) disable iff (reset)
      (valid_in[g] && !ready_in[g]) |=> valid_in[g]
    );
  end
`endif

endmodule

// File: tb/tb_cyclic_stream_mux.sv
module tb_cyclic_stream_mux;

  logic clk;
  logic reset;

  // three instances: NUM_REQS = 4, 3, 1 (index 0, 1, 2)
  logic [3:0]  vi  [3];
  logic [31:0] di  [3][4];
  logic        rdo [3];

  logic [3:0]  ri4;
  logic [2:0]  ri3;
  logic [0:0]  ri1;
  logic        vo4, vo3, vo1;
  logic [31:0] do4, do3, do1;
  logic [1:0]  so4, so3;
  logic [0:0]  so1;

  logic [3:0]  ri_w [3];
  logic        vo_w [3];
  logic [31:0] do_w [3];
  logic [1:0]  so_w [3];

  assign ri_w[0] = ri4;
  assign ri_w[1] = {1'b0, ri3};
  assign ri_w[2] = {3'b000, ri1};
  assign vo_w[0] = vo4;
  assign vo_w[1] = vo3;
  assign vo_w[2] = vo1;
  assign do_w[0] = do4;
  assign do_w[1] = do3;
  assign do_w[2] = do1;
  assign so_w[0] = so4;
  assign so_w[1] = so3;
  assign so_w[2] = {1'b0, so1};

  cyclic_stream_mux #(.NUM_REQS(4), .DATA_WIDTH(32)) dut4 (
    .clk(clk), .reset(reset), .valid_in(vi[0]),
    .data_in({di[0][3], di[0][2], di[0][1], di[0][0]}),
    .ready_in(ri4), .valid_out(vo4), .data_out(do4), .sel_out(so4),
    .ready_out(rdo[0]));

  cyclic_stream_mux #(.NUM_REQS(3), .DATA_WIDTH(32)) dut3 (
    .clk(clk), .reset(reset), .valid_in(vi[1][2:0]),
    .data_in({di[1][2], di[1][1], di[1][0]}),
    .ready_in(ri3), .valid_out(vo3), .data_out(do3), .sel_out(so3),
    .ready_out(rdo[1]));

  cyclic_stream_mux #(.NUM_REQS(1), .DATA_WIDTH(32)) dut1 (
    .clk(clk), .reset(reset), .valid_in(vi[2][0:0]),
    .data_in(di[2][0]),
    .ready_in(ri1), .valid_out(vo1), .data_out(do1), .sel_out(so1),
    .ready_out(rdo[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: slot = cycles since reset mod N; output buffer is a
  // FIFO of at most two beats.
  int          mptr [3];
  int          mcnt [3];
  logic [31:0] mdat [3][2];
  int          msel [3][2];
  int          acc  [3];   // input accepted at the last edge, -1 if none

  function automatic int nr(input int k);
    case (k)
      0: return 4;
      1: return 3;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mptr[k] = 0;
      mcnt[k] = 0;
      acc[k]  = -1;
    end
  endtask

  // Advance the model over the coming rising edge using the inputs now driven.
  task automatic step();
    if (reset) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 3; k++) begin
      bit push, pop;
      push   = (mcnt[k] < 2) && vi[k][mptr[k]];
      pop    = (mcnt[k] > 0) && rdo[k];
      acc[k] = push ? mptr[k] : -1;
      if (pop) begin
        mdat[k][0] = mdat[k][1];
        msel[k][0] = msel[k][1];
        mcnt[k]--;
      end
      if (push) begin
        mdat[k][mcnt[k]] = di[k][mptr[k]];
        msel[k][mcnt[k]] = mptr[k];
        mcnt[k]++;
      end
      mptr[k] = (mptr[k] + 1) % nr(k);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      logic [3:0] exp_ri;
      exp_ri = (!reset && mcnt[k] < 2) ? (4'b0001 << mptr[k]) : 4'b0000;
      chk($sformatf("valid_out[n%0d]", nr(k)), vo_w[k], mcnt[k] > 0);
      chk($sformatf("ready_in[n%0d]", nr(k)), ri_w[k], exp_ri);
      if (mcnt[k] > 0) begin
        chk($sformatf("data_out[n%0d]", nr(k)), do_w[k], mdat[k][0]);
        chk($sformatf("sel_out[n%0d]", nr(k)), so_w[k], msel[k][0]);
      end
      if (reset) begin
        chk($sformatf("rst_data[n%0d]", nr(k)), do_w[k], 0);
        chk($sformatf("rst_sel[n%0d]", nr(k)), so_w[k], 0);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
  endtask

  task automatic cyc();
    step();
    tick();
  endtask

  task automatic set_all_valid(input bit v, input bit r);
    for (int k = 0; k < 3; k++) begin
      vi[k]  = '0;
      rdo[k] = r;
      for (int i = 0; i < nr(k); i++) begin
        vi[k][i] = v;
        di[k][i] = 32'h1000_0000 + 32'(k * 16 + i);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_all_valid(1'b0, 1'b0);
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  int pulses, tx, rx;
  bit tog;

  initial begin
    reset = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 2; j++) begin
        mdat[k][j] = '0;
        msel[k][j] = 0;
      end
    end
    set_all_valid(1'b0, 1'b0);
    tick();
    chk("reset_ready_in4", ri4, 0);
    chk("reset_valid_out4", vo4, 0);
    cyc();
    reset = 1'b0;

    // all valid, ready_out=1: one beat per cycle, sel 0,1,2,3,...
    set_all_valid(1'b1, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      cyc();
      chk("thru_valid", vo4, 1);
      chk("thru_sel", so4, (c - 1) % 4);
      chk("thru_data", do4, di[0][(c - 1) % 4]);
    end

    // only input 2 valid with 0xA5
    do_reset();
    set_all_valid(1'b0, 1'b1);
    vi[0]    = 4'b0100;
    di[0][2] = 32'h0000_00A5;
    pulses   = 0;
    for (int c = 1; c <= 16; c++) begin
      cyc();
      if (vo4) begin
        pulses++;
        chk("single_data", do4, 32'hA5);
        chk("single_sel", so4, 2);
      end
    end
    chk("single_pulses", pulses, 4);

    // downstream stalled: two beats accepted then no grants
    do_reset();
    set_all_valid(1'b1, 1'b0);
    cyc();
    chk("stall_ready_c1", ri4, 4'b0010);
    for (int c = 2; c <= 5; c++) begin
      cyc();
      chk("stall_ready_full", ri4, 0);
    end
    chk("stall_head_sel", so4, 0);
    chk("stall_head_data", do4, di[0][0]);
    rdo[0] = 1'b1;
    cyc();
    chk("drain_valid", vo4, 1);
    chk("drain_sel", so4, 1);
    chk("drain_data", do4, di[0][1]);

    // non-power-of-two pointer wrap
    do_reset();
    set_all_valid(1'b1, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      cyc();
      chk("n3_ready", ri3, 3'b001 << (c % 3));
    end

    // asynchronous reset with a full buffer
    do_reset();
    set_all_valid(1'b1, 1'b0);
    cyc();
    cyc();
    cyc();
    chk("full_before_rst", ri4, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid_out", vo4, 0);
    chk("async_ready_in", ri4, 0);
    chk("async_data_out", do4, 0);
    chk("async_ready_in3", ri3, 0);
    model_reset();
    cyc();
    reset = 1'b0;
    set_all_valid(1'b1, 1'b1);
    cyc();
    chk("restart_valid", vo4, 1);
    chk("restart_sel", so4, 0);

    // single input, ready_out toggling
    do_reset();
    set_all_valid(1'b0, 1'b0);
    vi[2][0] = 1'b1;
    tx = 0;
    rx = 0;
    tog = 1'b1;
    di[2][0] = 32'hC000_0000;
    for (int c = 0; c < 100 && rx < 20; c++) begin
      if (acc[2] == 0) begin
        tx++;
        di[2][0] = 32'hC000_0000 + 32'(tx);
      end
      rdo[2] = tog;
      tog = ~tog;
      chk("n1_sel", so1, 0);
      if (vo1 && rdo[2]) begin
        chk("n1_seq", do1, 32'hC000_0000 + 32'(rx));
        rx++;
      end
      cyc();
    end
    chk("n1_beats", rx, 20);

    // randomized traffic, upstream holds each valid beat until accepted
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end
      for (int k = 0; k < 3; k++) begin
        rdo[k] = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < nr(k); i++) begin
          if (!(vi[k][i] && acc[k] != i)) begin
            vi[k][i] = ($urandom_range(0, 2) != 0);
            di[k][i] = $urandom;
          end
        end
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
